// File: rtl/ser_ctrl_pkg.sv
// Shared types and line constants for the pair-serializer sequencing controller.
package ser_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    PAR  = 2'd3
  } ser_state_t;

  localparam logic [1:0] IDLE_PAIR = 2'b11;
  localparam logic [1:0] PRE_PAIR  = 2'b10;

endpackage

// File: rtl/ser_pair_shifter.sv
// Word shift register presenting its two MSBs as the next pair to send.
// The parity port exists only when SER_PARITY_EN is defined.
module ser_pair_shifter
  import ser_ctrl_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              load,
  input  logic              pre_shift,
  input  logic              shift,
  input  logic [WORD_W-1:0] word,
  output logic [1:0]        pair
`ifdef SER_PARITY_EN
  ,
  output logic              parity
`endif
);

  logic [WORD_W-1:0] sreg;

  // pre_shift loads a word whose first pair is already being driven elsewhere
  always_ff @(posedge clk) begin
    if (load) begin
      sreg <= pre_shift ? {word[WORD_W-3:0], 2'b00} : word;
    end else if (shift) begin
      sreg <= {sreg[WORD_W-3:0], 2'b00};
    end
  end

  assign pair = sreg[WORD_W-1 -: 2];

`ifdef SER_PARITY_EN
  // Parity must cover the whole word, so it is taken at load time
  always_ff @(posedge clk) begin
    if (load) begin
      parity <= ^word;
    end
  end
`endif

endmodule

// File: rtl/ser_pair_feeder.sv
// Frames parallel words with a preamble and feeds a 2:1 serializer one pair per cycle.
// Optional trailing parity pair enabled by defining SER_PARITY_EN.
module ser_pair_feeder
  import ser_ctrl_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int PRE_PAIRS = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WORD_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              PAR_IN1,
  output logic              PAR_IN2,
  output logic              BUSY,
  output logic              WORD_DONE
);

  localparam int HALF    = WORD_W / 2;
  localparam int CNT_MAX = (PRE_PAIRS > HALF) ? PRE_PAIRS : HALF;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  ser_state_t    state;
  logic [CW-1:0] cnt;
  logic [1:0]    pair_q;
  logic          busy_q;
  logic          done_q;
  logic          final_c;
  logic          ready_c;
  logic          accept;
  logic          sh_load;
  logic          sh_pre_shift;
  logic          sh_shift;
  logic [1:0]    sh_pair;
`ifdef SER_PARITY_EN
  logic          word_parity;
`endif

`ifdef SER_PARITY_EN
  assign final_c = (state == PAR);
`else
  assign final_c = (state == DATA) && (cnt == '0);
`endif

  assign ready_c      = !RESET && ((state == IDLE) || final_c);
  assign accept       = ready_c && IN_VALID;
  assign sh_load      = accept;
  assign sh_pre_shift = (state != IDLE);
  assign sh_shift     = ((state == PRE) && (cnt == '0)) || ((state == DATA) && (cnt != '0));

  ser_pair_shifter #(
    .WORD_W (WORD_W)
  ) u_shifter (
    .clk       (CLK),
    .load      (sh_load),
    .pre_shift (sh_pre_shift),
    .shift     (sh_shift),
    .word      (IN_DATA),
    .pair      (sh_pair)
`ifdef SER_PARITY_EN
    ,
    .parity    (word_parity)
`endif
  );

  // Outputs are registered from the transition, so each state shows its own pair
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      pair_q <= IDLE_PAIR;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state  <= PRE;
            cnt    <= CW'(PRE_PAIRS - 1);
            pair_q <= PRE_PAIR;
            busy_q <= 1'b1;
          end
        end
        PRE: begin
          if (cnt == '0) begin
            state  <= DATA;
            cnt    <= CW'(HALF - 1);
            pair_q <= sh_pair;
          end else begin
            cnt    <= cnt - 1'b1;
            pair_q <= PRE_PAIR;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt    <= cnt - 1'b1;
            pair_q <= sh_pair;
`ifndef SER_PARITY_EN
            done_q <= (cnt == CW'(1));
`endif
          end else begin
`ifdef SER_PARITY_EN
            state  <= PAR;
            pair_q <= {word_parity, ~word_parity};
            done_q <= 1'b1;
`else
            // Back-to-back word: its first pair goes straight out, no preamble
            if (accept) begin
              cnt    <= CW'(HALF - 1);
              pair_q <= IN_DATA[WORD_W-1 -: 2];
              done_q <= (HALF == 1);
            end else begin
              state  <= IDLE;
              pair_q <= IDLE_PAIR;
              busy_q <= 1'b0;
            end
`endif
          end
        end
`ifdef SER_PARITY_EN
        PAR: begin
          if (accept) begin
            state  <= DATA;
            cnt    <= CW'(HALF - 1);
            pair_q <= IN_DATA[WORD_W-1 -: 2];
          end else begin
            state  <= IDLE;
            pair_q <= IDLE_PAIR;
            busy_q <= 1'b0;
          end
        end
`endif
        default: begin
          state  <= IDLE;
          pair_q <= IDLE_PAIR;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY  = ready_c;
  assign PAR_IN1   = pair_q[1];
  assign PAR_IN2   = pair_q[0];
  assign BUSY      = busy_q;
  assign WORD_DONE = done_q;

endmodule

// File: tb/tb_ser_pair_feeder.sv
// Randomized bench for ser_pair_feeder against a queue-based schedule of expected line pairs.
// Honours SER_PARITY_EN the same way as the design.
module tb_ser_pair_feeder;

  localparam int WORD_W    = 8;
  localparam int PRE_PAIRS = 2;
  localparam int HALF      = WORD_W / 2;
`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic p1;
    logic p2;
    logic busy;
    logic done;
  } ent_t;

  localparam ent_t IDLE_ENT = '{p1: 1'b1, p2: 1'b1, busy: 1'b0, done: 1'b0};

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              IN_VALID = 1'b0;
  logic [WORD_W-1:0] IN_DATA = '0;
  logic              IN_READY;
  logic              PAR_IN1;
  logic              PAR_IN2;
  logic              BUSY;
  logic              WORD_DONE;

  int   vectors = 0;
  int   miscompares = 0;
  ent_t cur = IDLE_ENT;
  ent_t sched[$];
  bit   model_live = 1'b0;

  ser_pair_feeder #(
    .WORD_W    (WORD_W),
    .PRE_PAIRS (PRE_PAIRS)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .PAR_IN1   (PAR_IN1),
    .PAR_IN2   (PAR_IN2),
    .BUSY      (BUSY),
    .WORD_DONE (WORD_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Line pairs an accepted word produces, from its first cycle on the line
  task automatic queueWord(input logic [WORD_W-1:0] w, input bit with_pre);
    ent_t e;
    if (with_pre) begin
      for (int i = 0; i < PRE_PAIRS; i++) begin
        e = '{p1: 1'b1, p2: 1'b0, busy: 1'b1, done: 1'b0};
        sched.push_back(e);
      end
    end
    for (int k = 0; k < HALF; k++) begin
      e.p1   = w[WORD_W-1-2*k];
      e.p2   = w[WORD_W-2-2*k];
      e.busy = 1'b1;
      e.done = (k == HALF - 1) && !PAR_EN;
      sched.push_back(e);
    end
    if (PAR_EN) begin
      e = '{p1: ^w, p2: ~(^w), busy: 1'b1, done: 1'b1};
      sched.push_back(e);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [WORD_W-1:0] d);
    bit exp_ready;
    bit accepted;
    RESET    = r;
    IN_VALID = v;
    IN_DATA  = d;
    #1;
    exp_ready = !r && (!cur.busy || cur.done);
    accepted  = exp_ready && v;
    if (model_live) begin
      checkOutput("par_in1",   PAR_IN1,   cur.p1);
      checkOutput("par_in2",   PAR_IN2,   cur.p2);
      checkOutput("busy",      BUSY,      cur.busy);
      checkOutput("word_done", WORD_DONE, cur.done);
      checkOutput("in_ready",  IN_READY,  exp_ready);
    end
    @(posedge CLK);
    if (r) begin
      sched.delete();
      cur        = IDLE_ENT;
      model_live = 1'b1;
    end else if (model_live) begin
      if (accepted) queueWord(d, !cur.busy);
      cur = (sched.size() > 0) ? sched.pop_front() : IDLE_ENT;
    end
    #1;
  endtask

  initial begin
    logic [WORD_W-1:0] rnd;
    repeat (3) applyStimulus(1'b1, 1'b0, '0);
    repeat (3) applyStimulus(1'b0, 1'b0, '0);

    applyStimulus(1'b0, 1'b1, 8'hB4);
    repeat (8) applyStimulus(1'b0, 1'b0, '0);

    applyStimulus(1'b0, 1'b1, 8'hB4);
    repeat (7) applyStimulus(1'b0, 1'b1, 8'h5A);
    repeat (7) applyStimulus(1'b0, 1'b0, '0);

    applyStimulus(1'b0, 1'b1, 8'h3C);
    repeat (3) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b1, 8'h77);
    repeat (2) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 8'h80);
    repeat (8) applyStimulus(1'b0, 1'b0, '0);

    applyStimulus(1'b0, 1'b1, 8'hE1);
    for (int k = 0; k < 6; k++) begin
      rnd = WORD_W'($urandom);
      applyStimulus(1'b0, k[0], rnd);
    end
    repeat (4) applyStimulus(1'b0, 1'b0, '0);

    repeat (400) begin
      rnd = WORD_W'($urandom);
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, rnd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ser_pair_feeder.md
# ser_pair_feeder

Sequencing controller that sits in front of the 2:1 DDR-style output serializer. It accepts parallel words on a valid/ready interface, frames them with a preamble, and drives the serializer's two parallel inputs one bit-pair per CLK cycle, MSB first. When no data is pending it drives an idle line pattern. The serializer then emits both bits of each pair within that cycle.

## Interface
Parameters:
- WORD_W, 16, payload width in bits; even, ≥ 4
- PRE_PAIRS, 2, number of preamble pairs sent before a non-back-to-back word; ≥ 1

Ports:
- CLK  input  1  single clock; serializer shares it
- RESET  input  1  synchronous, active-high reset
- IN_DATA  input  WORD_W  word to transmit
- IN_VALID  input  1  IN_DATA valid
- IN_READY  output  1  word accepted on a cycle with IN_VALID && IN_READY
- PAR_IN1  output  1  first (earlier) bit of the current pair, registered
- PAR_IN2  output  1  second bit of the current pair, registered
- BUSY  output  1  high when the state is not IDLE, registered
- WORD_DONE  output  1  one-cycle pulse with the final pair of each word, registered

## Operation
- States are IDLE, PRE, DATA and PAR. PAR exists only with the parity macro.
- Idle pair is (1,1). Preamble pair is (1,0).
- IDLE:
  - Outputs the idle pair. IN_READY=1.
  - On acceptance, capture IN_DATA into the shift register, load the counter with PRE_PAIRS-1 and go to PRE.
- PRE:
  - Outputs the preamble pair once per cycle.
  - When the counter reaches 0, load it with WORD_W/2-1 and go to DATA.
- DATA:
  - Pair k (k=0..WORD_W/2-1) is (D[W-1-2k], D[W-2-2k]). Shift left by 2 each cycle.
  - The last pair is the cycle with counter==0.
  - Without parity:
    - IN_READY=1 on the last-pair cycle.
    - If a word is accepted, reload the shift register and counter and stay in DATA, with no preamble.
    - Otherwise go to IDLE.
  - With parity: after the last pair, go to PAR.
- IN_READY = !RESET && (state==IDLE || final-pair cycle). It is combinational from the state and counter, and never depends on IN_VALID.
- The counter is $clog2(max(PRE_PAIRS, WORD_W/2)) bits wide and counts down.

## Timing
- Reset value of every output: PAR_IN1=1, PAR_IN2=1, BUSY=0, WORD_DONE=0, IN_READY=0 while RESET is high. State is IDLE after reset.
- Word accepted in IDLE at cycle t:
  - Preamble pairs appear on PAR_IN at t+1..t+PRE_PAIRS.
  - Data pair 0 appears at t+PRE_PAIRS+1.
  - The final pair and WORD_DONE appear at t+PRE_PAIRS+WORD_W/2.
- Back-to-back word accepted on the final-pair cycle t: its pair 0 appears at t+1. No idle or preamble gap.
- BUSY rises at t+1 and falls on the first idle-pair cycle.
- IN_VALID deasserted mid-word has no effect; the captured word always completes.
- RESET asserted mid-word: the next cycle outputs the idle pair, with BUSY=0 and WORD_DONE=0. The in-flight word is discarded and no partial pair is emitted.
- RESET and IN_VALID in the same cycle: no acceptance.

## Configuration
- SER_PARITY_EN, when defined:
  - Adds state PAR, entered after the last data pair.
  - PAR outputs (P, ~P) for one cycle, where P = ^word (even parity).
  - WORD_DONE and IN_READY move from the last data-pair cycle to the PAR cycle.
  - Back-to-back acceptance in PAR goes to DATA.
  - Word period is WORD_W/2+1 cycles.
- Undefined: no PAR state, and the word period is WORD_W/2 cycles.

## Structure
- Shared package ser_ctrl_pkg holds:
  - the state enum (IDLE, PRE, DATA, PAR)
  - constants IDLE_PAIR=2'b11 and PRE_PAIR=2'b10
- One sub-module, ser_pair_shifter, holds the WORD_W shift register with load and shift-by-2 controls and a parity output. The FSM and counter stay in the top.

## Test plan
- Reset then idle, RESET=1 for 3 cycles then 0, no IN_VALID -> PAR_IN=(1,1), BUSY=0, IN_READY=0 during reset and 1 after.
- WORD_W=8, PRE_PAIRS=2, 0xB4 accepted at t -> pairs (1,0),(1,0),(1,0),(1,1),(0,1),(0,0) at t+1..t+6. WORD_DONE only at t+6, then (1,1).
- Back-to-back 0xB4 then 0x5A, IN_VALID held -> second accepted at t+6, pairs (0,1),(0,1),(1,0),(1,0) at t+7..t+10 with no preamble.
- SER_PARITY_EN, 0xB4 -> after the data pairs, (0,1) at t+7 with WORD_DONE; 0x80 gives parity pair (1,0).
- RESET pulsed at t+4 of a word -> (1,1) at t+5, BUSY=0, WORD_DONE never pulses, and a new word is accepted normally afterwards.
- IN_VALID dropped and IN_DATA changed mid-word -> the original word's pairs are unchanged, and IN_READY stays 0 until the final-pair cycle.
